pll_reset_sequencer: RTL
========================

Name: pll_reset_sequencer

Overview:
- Reset-release controller that sits around the system PLL wrapper in the Qsys clock/reset subsystem.
- Upstream of the PLL, it drives the PLL reset. Downstream, it consumes the asynchronous PLL lock flag, qualifies it, and releases per-clock-domain resets in a fixed staggered order.
- Recovers automatically from lock loss and from a lock timeout.
- Runs on the free-running 50 MHz board reference clock, which is the same clock that feeds the PLL.

Parameters:
- LOCK_SYNC_STAGES, 2: synchroniser depth on pll_locked; minimum 2.
- PLL_RST_CYCLES, 16: length of each pll_rst pulse, in clk cycles; minimum 1.
- LOCK_STABLE_CYCLES, 1024: consecutive synchronised-lock-high cycles required before any release.
- LOCK_TIMEOUT_CYCLES, 65536: WAIT_LOCK cycles allowed before the PLL is reset again.
- NUM_DOMAINS, 5: number of domain reset outputs; one per PLL output clock.
- STAGGER_CYCLES, 8: spacing between successive domain releases.

Ports:
- clk  in  1  free-running reference clock.
- reset_n  in  1  synchronous active-low reset.
- pll_locked  in  1  PLL lock flag; asynchronous to clk.
- sw_reset_req  in  1  single-cycle request for a full re-sequence.
- pll_rst  out  1  active-high reset to the PLL.
- domain_reset_n  out  NUM_DOMAINS  active-low reset per domain; bit i is released i-th.
- all_ready  out  1  high when every domain has been released and lock is held.
- lock_loss_count  out  8  count of lock losses in RELEASE/RUN; saturates at 255.
- seq_state  out  3  current state encoding, for debug.

Behaviour:
- All state and outputs are registered. reset_n is sampled on the rising edge of clk only.
- While reset_n=0:
  - state=PLL_RST, cycle counter=0, synchroniser flops=0.
  - pll_rst=1, domain_reset_n=all 0, all_ready=0, lock_loss_count=0.
- lock_s is pll_locked after LOCK_SYNC_STAGES flops. All decisions use lock_s only.
- One shared cycle counter cnt, cleared on every state entry. It is sized with clog2 of the largest parameter.
- State encodings: PLL_RST=0, WAIT_LOCK=1, STABLE=2, RELEASE=3, RUN=4.
- PLL_RST:
  - pll_rst=1, all domain_reset_n=0, all_ready=0.
  - Exit to WAIT_LOCK when cnt==PLL_RST_CYCLES-1. pll_rst therefore stays high for exactly PLL_RST_CYCLES cycles after reset_n rises.
  - sw_reset_req is ignored in this state.
- WAIT_LOCK:
  - pll_rst=0.
  - If lock_s=1, go to STABLE.
  - Else if cnt==LOCK_TIMEOUT_CYCLES-1, go to PLL_RST. The timeout does not increment lock_loss_count.
- STABLE:
  - If lock_s=0, return to WAIT_LOCK; the stability count restarts.
  - If lock_s has been 1 for LOCK_STABLE_CYCLES consecutive cycles (cnt==LOCK_STABLE_CYCLES-1), go to RELEASE.
- RELEASE:
  - When cnt==i*STAGGER_CYCLES, domain_reset_n[i] goes to 1 on the next edge and stays 1. domain_reset_n[0] therefore rises on the first edge after RELEASE is entered.
  - After bit NUM_DOMAINS-1 is released, go to RUN on the following cycle.
- RUN:
  - all_ready=1.
  - Remain in RUN while lock_s=1 and sw_reset_req=0.
- Lock loss in RELEASE or RUN (lock_s=0):
  - Next edge: all domain_reset_n=0, all_ready=0, state=PLL_RST.
  - lock_loss_count increments, saturating at 255.
- sw_reset_req=1 in any state other than PLL_RST:
  - Next edge: state=PLL_RST, all domain resets asserted, all_ready=0, lock_loss_count unchanged.
- Lock loss and sw_reset_req in the same cycle: go to PLL_RST and increment lock_loss_count.
- Domain resets are never released out of order. No domain is released unless lock_s has been continuously high from STABLE entry.
- reset_n asserted mid-sequence: every output returns to its reset value on the next edge, including lock_loss_count=0.

Test Plan:
Bench parameters for all scenarios: PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=16, STAGGER_CYCLES=2, LOCK_TIMEOUT_CYCLES=64, NUM_DOMAINS=5, LOCK_SYNC_STAGES=2.
1. Clean start: reset_n released at cycle 0, pll_locked rises at cycle 10 and stays high -> pll_rst high for cycles 0-3. STABLE is entered 3 cycles after the pll_locked rise. domain_reset_n steps 00001, 00011, 00111, 01111, 11111 at 2-cycle spacing. all_ready=1 one cycle after the last step.
2. Lock timeout: pll_locked held 0 -> pll_rst re-pulses for 4 cycles every 68 cycles. Domains stay 0. lock_loss_count stays 0.
3. Lock glitch during STABLE: pll_locked drops for 3 cycles after 10 stable cycles -> return to WAIT_LOCK, then a full 16-cycle requalification. No domain is released early. Count stays 0.
4. Lock loss in RUN: pll_locked falls -> 3 cycles later all domain_reset_n=0, all_ready=0, pll_rst=1, lock_loss_count=1. Full re-sequence follows once lock returns.
5. Saturation and simultaneous events: 260 forced lock losses -> lock_loss_count=255. Lock loss together with sw_reset_req -> count increments once (check this before saturation). sw_reset_req alone in RUN -> re-sequence with count unchanged.
6. reset_n pulled low mid-RELEASE with 3 domains released -> next edge: all outputs at reset values, count=0.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// Reset-release sequencer around the system PLL: pulses the PLL reset, qualifies lock,
// then releases the per-clock-domain resets one by one and recovers from lock loss or timeout.
module pll_reset_sequencer #(
    parameter int LOCK_SYNC_STAGES    = 2,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int NUM_DOMAINS         = 5,
    parameter int STAGGER_CYCLES      = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   pll_locked,
    input  logic                   sw_reset_req,
    output logic                   pll_rst,
    output logic [NUM_DOMAINS-1:0] domain_reset_n,
    output logic                   all_ready,
    output logic [7:0]             lock_loss_count,
    output logic [2:0]             seq_state
);

    localparam int LAST_REL = (NUM_DOMAINS - 1) * STAGGER_CYCLES;
    localparam int MAX_A    = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int MAX_B    = (MAX_A > LOCK_TIMEOUT_CYCLES) ? MAX_A : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_C    = (MAX_B > LAST_REL + 2) ? MAX_B : LAST_REL + 2;
    localparam int CNT_W    = (MAX_C < 2) ? 1 : $clog2(MAX_C);

    localparam logic [CNT_W-1:0] C_RST_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_TO_LAST   = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_STB_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_REL_DONE  = CNT_W'(LAST_REL + 1);

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_next;
    logic [LOCK_SYNC_STAGES-1:0] r_sync;
    logic                    w_lock_s;
    logic [NUM_DOMAINS-1:0]  r_dom;
    logic [NUM_DOMAINS-1:0]  w_dom_next;
    logic [NUM_DOMAINS-1:0]  w_rel_hit;
    logic [7:0]              r_llc;
    logic [7:0]              w_llc_next;
    logic                    w_loss;
    logic                    r_pll_rst;
    logic                    w_pll_rst_next;
    logic                    r_all_ready;
    logic                    w_all_ready_next;

    // pll_locked comes from the PLL's own domain; only the last stage is ever used.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[LOCK_SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign w_lock_s = r_sync[LOCK_SYNC_STAGES-1];

    for (genvar gi = 0; gi < NUM_DOMAINS; gi++) begin : g_rel
        localparam logic [CNT_W-1:0] C_AT = CNT_W'(gi * STAGGER_CYCLES);
        assign w_rel_hit[gi] = (r_cnt == C_AT);
    end

    always_comb begin
        w_state_next = r_state;
        w_loss       = 1'b0;
        case (r_state)
            ST_PLL_RST: begin
                if (r_cnt == C_RST_LAST) w_state_next = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (sw_reset_req)             w_state_next = ST_PLL_RST;
                else if (w_lock_s)            w_state_next = ST_STABLE;
                else if (r_cnt == C_TO_LAST)  w_state_next = ST_PLL_RST;
            end
            ST_STABLE: begin
                if (sw_reset_req)             w_state_next = ST_PLL_RST;
                else if (!w_lock_s)           w_state_next = ST_WAIT_LOCK;
                else if (r_cnt == C_STB_LAST) w_state_next = ST_RELEASE;
            end
            ST_RELEASE, ST_RUN: begin
                // Lock loss wins over a simultaneous software request so it is still counted.
                if (!w_lock_s) begin
                    w_loss       = 1'b1;
                    w_state_next = ST_PLL_RST;
                end else if (sw_reset_req) begin
                    w_state_next = ST_PLL_RST;
                end else if (r_state == ST_RELEASE && r_cnt == C_REL_DONE) begin
                    w_state_next = ST_RUN;
                end
            end
            default: w_state_next = ST_PLL_RST;
        endcase

        if (w_state_next != r_state) begin
            w_cnt_next = '0;
        end else if (r_state == ST_RUN) begin
            w_cnt_next = r_cnt;
        end else begin
            w_cnt_next = r_cnt + 1'b1;
        end

        w_dom_next = r_dom;
        if (w_state_next == ST_PLL_RST) begin
            w_dom_next = '0;
        end else if (r_state == ST_RELEASE) begin
            w_dom_next = r_dom | w_rel_hit;
        end

        w_llc_next       = (w_loss && r_llc != 8'hFF) ? r_llc + 8'd1 : r_llc;
        w_pll_rst_next   = (w_state_next == ST_PLL_RST);
        w_all_ready_next = (w_state_next == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_PLL_RST;
            r_cnt       <= '0;
            r_dom       <= '0;
            r_llc       <= '0;
            r_pll_rst   <= 1'b1;
            r_all_ready <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_dom       <= w_dom_next;
            r_llc       <= w_llc_next;
            r_pll_rst   <= w_pll_rst_next;
            r_all_ready <= w_all_ready_next;
        end
    end

    assign pll_rst         = r_pll_rst;
    assign domain_reset_n  = r_dom;
    assign all_ready       = r_all_ready;
    assign lock_loss_count = r_llc;
    assign seq_state       = r_state;

endmodule
